// File: rtl/katana_tracker.sv
// katana_tracker: per-frame centre of mass of katana-coloured pixels.
// Sums hcount/vcount/count of masked active pixels. At frame end a
// sequential restoring divider computes sum/cnt for x then y and publishes
// the result.
// Optional build macro: KATANA_SMOOTH_EN. When it is defined, each update
// moves the position halfway toward the new quotient instead of jumping to it.
//
// Output protocol: katana_valid_out is a one-cycle strobe with no ready or
// back-pressure. katana_x/katana_y/katana_present_out change on the same edge
// that raises it and hold until the next strobe. The consumer must sample
// them in that cycle or read the held values later.
module katana_tracker #(
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  parameter int MIN_PIXELS = 64,
  parameter int SUM_W      = 30,
  parameter int CNT_W      = 20
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        mask_in,
  output logic [10:0] katana_x,
  output logic [9:0]  katana_y,
  output logic        katana_valid_out,
  output logic        katana_present_out,
  output logic        overrun_out,
  output logic [1:0]  state_dbg
);

  localparam int BIT_W = $clog2(SUM_W);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIV_X  = 2'd1,
    DIV_Y  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t state, next_state;

  logic             frame_done;
  logic             pix_active;
  logic [SUM_W-1:0] sum_x, sum_y;
  logic [CNT_W-1:0] cnt;

  logic [SUM_W-1:0] div_num;   // dividend shifting out, quotient shifting in
  logic [SUM_W-1:0] div_rem;
  logic [CNT_W-1:0] div_den;
  logic [SUM_W-1:0] lat_sum_y;
  logic [10:0]      quot_x;
  logic [BIT_W-1:0] bit_cnt;
  logic             cnt_ok;

  logic [SUM_W:0]   rem_shift;
  logic [SUM_W:0]   den_ext;
  logic             q_bit;
  logic [SUM_W-1:0] rem_next;
  logic [SUM_W-1:0] num_next;
  logic             last_iter;
  logic [10:0]      new_x;
  logic [9:0]       new_y;

  assign frame_done = (hcount_in == 11'(H_ACTIVE)) && (vcount_in == 10'(V_ACTIVE));
  assign pix_active = (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
  assign state_dbg  = state;

  // Frame accumulators: run every cycle and clear at frame end whatever the FSM is doing.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (frame_done) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (pix_active && mask_in) begin
      sum_x <= sum_x + {{(SUM_W-11){1'b0}}, hcount_in};
      sum_y <= sum_y + {{(SUM_W-10){1'b0}}, vcount_in};
      cnt   <= cnt + 1'b1;
    end
  end

  // One restoring-division step: shift in the next dividend bit, then subtract if it fits.
  always_comb begin
    rem_shift = {div_rem, div_num[SUM_W-1]};
    den_ext   = {{(SUM_W+1-CNT_W){1'b0}}, div_den};
    q_bit     = (rem_shift >= den_ext);
    // When nothing is subtracted the shifted remainder is below the divisor, so the top bit is 0.
    rem_next  = q_bit ? SUM_W'(rem_shift - den_ext) : rem_shift[SUM_W-1:0];
    num_next  = {div_num[SUM_W-2:0], q_bit};
    last_iter = (bit_cnt == BIT_W'(SUM_W-1));
  end

  // Position to publish. The y quotient completes on this same edge, so take it from num_next.
  always_comb begin
`ifdef KATANA_SMOOTH_EN
    logic signed [11:0] diff_x, sum_sx;
    logic signed [10:0] diff_y, sum_sy;
    diff_x = signed'({1'b0, quot_x}) - signed'({1'b0, katana_x});
    sum_sx = signed'({1'b0, katana_x}) + (diff_x >>> 1);
    diff_y = signed'({1'b0, num_next[9:0]}) - signed'({1'b0, katana_y});
    sum_sy = signed'({1'b0, katana_y}) + (diff_y >>> 1);
    new_x  = 11'(sum_sx);
    new_y  = 10'(sum_sy);
`else
    new_x = quot_x;
    new_y = num_next[9:0];
`endif
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= ACCUM;
    else         state <= next_state;
  end

  // Next-state logic. Both divisions always run their full length, so latency is fixed.
  always_comb begin
    next_state = state;
    case (state)
      ACCUM:   if (frame_done) next_state = DIV_X;
      DIV_X:   if (last_iter)  next_state = DIV_Y;
      DIV_Y:   if (last_iter)  next_state = UPDATE;
      UPDATE:  next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  // Divider datapath: latch the frame at frame end, then iterate x followed by y.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      div_num   <= '0;
      div_rem   <= '0;
      div_den   <= '0;
      lat_sum_y <= '0;
      quot_x    <= '0;
      bit_cnt   <= '0;
      cnt_ok    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (frame_done) begin
            div_num   <= sum_x;
            div_rem   <= '0;
            div_den   <= cnt;
            lat_sum_y <= sum_y;
            cnt_ok    <= (cnt >= CNT_W'(MIN_PIXELS));
            bit_cnt   <= '0;
          end
        end
        DIV_X: begin
          bit_cnt <= last_iter ? '0 : bit_cnt + 1'b1;
          if (last_iter) begin
            quot_x  <= num_next[10:0];
            div_num <= lat_sum_y;
            div_rem <= '0;
          end else begin
            div_num <= num_next;
            div_rem <= rem_next;
          end
        end
        DIV_Y: begin
          bit_cnt <= last_iter ? '0 : bit_cnt + 1'b1;
          div_num <= num_next;
          div_rem <= rem_next;
        end
        default: ;
      endcase
    end
  end

  // Published outputs. They update on the edge that enters UPDATE, so the strobe is high during UPDATE.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      katana_x           <= 11'(H_ACTIVE / 2);
      katana_y           <= 10'(V_ACTIVE / 2);
      katana_valid_out   <= 1'b0;
      katana_present_out <= 1'b0;
      overrun_out        <= 1'b0;
    end else begin
      katana_valid_out <= 1'b0;
      overrun_out      <= frame_done && (state != ACCUM);
      if (state == DIV_Y && last_iter) begin
        katana_valid_out   <= 1'b1;
        katana_present_out <= cnt_ok;
        if (cnt_ok) begin
          katana_x <= new_x;
          katana_y <= new_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_katana_tracker.sv
// Directed bench for katana_tracker: table of frames plus overrun and mid-division reset sequences.
// Two instances share stimulus: dut0 uses MIN_PIXELS=64, dut1 uses MIN_PIXELS=1.
module tb_katana_tracker;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        mask_in = 1'b0;

  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
  logic        v0, v1, p0, p1, o0, o1;
  logic [1:0]  s0, s1;

  katana_tracker dut0 (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .mask_in(mask_in), .katana_x(x0), .katana_y(y0), .katana_valid_out(v0),
    .katana_present_out(p0), .overrun_out(o0), .state_dbg(s0)
  );

  katana_tracker #(.MIN_PIXELS(1)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .mask_in(mask_in), .katana_x(x1), .katana_y(y1), .katana_valid_out(v1),
    .katana_present_out(p1), .overrun_out(o1), .state_dbg(s1)
  );

  // Clock and cycle counter.
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Pulse monitor: counts strobes and records the cycle of the latest one.
  int vcnt0 = 0, vcnt1 = 0, vcyc0 = 0, vcyc1 = 0, ocnt0 = 0, ocnt1 = 0;
  always @(negedge clk_in) begin
    if (v0) begin vcnt0 <= vcnt0 + 1; vcyc0 <= cyc; end
    if (v1) begin vcnt1 <= vcnt1 + 1; vcyc1 <= cyc; end
    if (o0) ocnt0 <= ocnt0 + 1;
    if (o1) ocnt1 <= ocnt1 + 1;
  end

  int total = 0;
  int bad = 0;

  // Expected model state per instance.
  int ex0 = 512, ey0 = 384, ep0 = 0;
  int ex1 = 512, ey1 = 384, ep1 = 0;
  int fd_cyc, base_v0, base_v1, base_o0;

  typedef struct {
    int bx; int by; int bw; int bh; int noise;
    int pres0; int pres1; int qx; int qy;
  } frame_vec_t;

  frame_vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int upd(input int cur, input int q);
`ifdef KATANA_SMOOTH_EN
    return cur + ((q - cur) >>> 1);
`else
    return q;
`endif
  endfunction

  // Driver: one pixel per cycle, applied at the falling edge.
  task automatic pix(input int h, input int v, input int m);
    @(negedge clk_in);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    mask_in   = 1'(m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(0, 0, 0);
  endtask

  task automatic block(input int bx, input int by, input int bw, input int bh);
    for (int r = 0; r < bh; r++)
      for (int c = 0; c < bw; c++) pix(bx + c, by + r, 1);
  endtask

  task automatic frame_end();
    base_v0 = vcnt0;
    base_v1 = vcnt1;
    base_o0 = ocnt0;
    pix(1024, 768, 0);
    fd_cyc = cyc;
  endtask

  // Waits out the fixed latency, then checks the strobe count and timing and compares outputs with the model.
  task automatic check_result(input string tag, input int pres0, input int pres1, input int qx, input int qy);
    idle(70);
    if (pres0 != 0) begin ex0 = upd(ex0, qx); ey0 = upd(ey0, qy); end
    if (pres1 != 0) begin ex1 = upd(ex1, qx); ey1 = upd(ey1, qy); end
    ep0 = pres0;
    ep1 = pres1;
    chk({tag, " valid_count0"}, vcnt0 - base_v0, 1);
    chk({tag, " valid_count1"}, vcnt1 - base_v1, 1);
    chk({tag, " latency0"}, vcyc0 - fd_cyc, 61);
    chk({tag, " latency1"}, vcyc1 - fd_cyc, 61);
    chk({tag, " x0"}, int'(x0), ex0);
    chk({tag, " y0"}, int'(y0), ey0);
    chk({tag, " present0"}, int'(p0), ep0);
    chk({tag, " x1"}, int'(x1), ex1);
    chk({tag, " y1"}, int'(y1), ey1);
    chk({tag, " present1"}, int'(p1), ep1);
  endtask

  initial begin
    // Frames: block origin/size, out-of-range noise flag, expected presence, expected quotients.
    vecs[0] = '{bx:10,   by:20,  bw:9,  bh:7,  noise:0, pres0:0, pres1:1, qx:14,   qy:23};
    vecs[1] = '{bx:100,  by:200, bw:10, bh:10, noise:0, pres0:1, pres1:1, qx:104,  qy:204};
    vecs[2] = '{bx:0,    by:0,   bw:8,  bh:8,  noise:0, pres0:1, pres1:1, qx:3,    qy:3};
    vecs[3] = '{bx:1023, by:767, bw:1,  bh:1,  noise:1, pres0:0, pres1:1, qx:1023, qy:767};
    vecs[4] = '{bx:300,  by:50,  bw:8,  bh:8,  noise:0, pres0:1, pres1:1, qx:303,  qy:53};

    // Reset state.
    repeat (3) @(negedge clk_in);
    chk("reset x0", int'(x0), 512);
    chk("reset y0", int'(y0), 384);
    chk("reset flags0", int'({v0, p0, o0}), 0);
    chk("reset state0", int'(s0), 0);
    chk("reset x1", int'(x1), 512);
    chk("reset flags1", int'({v1, p1, o1}), 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(2);

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      block(vecs[i].bx, vecs[i].by, vecs[i].bw, vecs[i].bh);
      if (vecs[i].noise != 0) begin
        for (int h = 1024; h < 1344; h++) pix(h, 5, 1);
        for (int v = 768; v < 1024; v++) pix(3, v, 1);
      end
      idle(2);
      frame_end();
      check_result($sformatf("vec%0d", i), vecs[i].pres0, vecs[i].pres1, vecs[i].qx, vecs[i].qy);
    end

    // Overrun: a second frame end 10 cycles into the division must be dropped.
    block(100, 200, 10, 10);
    frame_end();
    for (int i = 0; i < 5; i++) pix(900, 700, 1);
    idle(4);
    pix(1024, 768, 0);
    check_result("overrun frame", 1, 1, 104, 204);
    chk("overrun pulses0", ocnt0 - base_o0, 1);
    chk("overrun pulses1", ocnt1, 1);
    block(300, 50, 8, 8);
    frame_end();
    check_result("after overrun", 1, 1, 303, 53);
    chk("no extra overrun", ocnt0 - base_o0, 0);

    // Reset in the 30th cycle of DIV_X aborts the division.
    block(100, 200, 10, 10);
    frame_end();
    idle(30);
    chk("div_x state", int'(s0), 1);
    base_v0 = vcnt0;
    base_v1 = vcnt1;
    #2 rst_in = 1'b0;
    #1;
    chk("async rst x0", int'(x0), 512);
    chk("async rst y0", int'(y0), 384);
    chk("async rst flags0", int'({v0, p0, o0}), 0);
    chk("async rst state0", int'(s0), 0);
    chk("async rst x1", int'(x1), 512);
    chk("async rst present1", int'(p1), 0);
    ex0 = 512; ey0 = 384; ep0 = 0;
    ex1 = 512; ey1 = 384; ep1 = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(80);
    chk("no valid after reset0", vcnt0 - base_v0, 0);
    chk("no valid after reset1", vcnt1 - base_v1, 0);
    block(100, 200, 10, 10);
    frame_end();
    check_result("post reset", 1, 1, 104, 204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
